// File: rtl/rx_ctrl_pkg.sv
// Shared definitions for the C-PHY receive lane control block: decoder
// code values, FSM state encodings and state classification helpers.
package rx_ctrl_pkg;

  // 2-bit codes from the LP control decoder
  localparam logic [1:0] CODE_STOP   = 2'b00;
  localparam logic [1:0] CODE_HSRQ   = 2'b01;
  localparam logic [1:0] CODE_BRIDGE = 2'b10;
  localparam logic [1:0] CODE_LPRQ   = 2'b11;

  // Encodings are visible on StateOut, so they are fixed explicitly
  typedef enum logic [3:0] {
    ST_DISABLED  = 4'd0,
    ST_WAIT_STOP = 4'd1,
    ST_STOP      = 4'd2,
    ST_HS_RQST   = 4'd3,
    ST_HS_PREP   = 4'd4,
    ST_HS_SETTLE = 4'd5,
    ST_HS_RX     = 4'd6,
    ST_HS_EXIT   = 4'd7,
    ST_LP_RQST   = 4'd8,
    ST_LP_YIELD  = 4'd9,
    ST_TA_RQST   = 4'd10,
    ST_ERR       = 4'd11
  } state_e;

  // LP sequencing states guarded by the timeout counter
  function automatic logic is_timed_state(input state_e s);
    return (s == ST_HS_RQST) || (s == ST_HS_EXIT) || (s == ST_LP_RQST) ||
           (s == ST_LP_YIELD) || (s == ST_TA_RQST);
  endfunction

  // States where the decoder is off and its output (00) is meaningless
  function automatic logic is_decoder_off(input state_e s);
    return (s == ST_DISABLED) || (s == ST_HS_SETTLE) || (s == ST_HS_RX);
  endfunction

endpackage

// File: rtl/rx_ctrl_glitch_filter.sv
// Glitch filter for the LP control code. A code is accepted after
// FILT_CYCLES consecutive identical samples; CodeEvt pulses for one cycle
// when the accepted code changes or when nothing was accepted since Clear.
// Ports: Clk, Rst (sync, active-high), Clear (forget accepted code),
//        CodeIn[1:0] raw decoder code, AccCode[1:0] accepted code,
//        CodeEvt one-cycle acceptance event.
module rx_ctrl_glitch_filter
  import rx_ctrl_pkg::*;
#(
  parameter int unsigned FILT_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Clear,
  input  logic [1:0] CodeIn,
  output logic [1:0] AccCode,
  output logic       CodeEvt
);

  localparam int unsigned CW = $clog2(FILT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cand_q, cand_d;
  logic [1:0]    acc_q, acc_d;
  logic          nocode_q, nocode_d;
  logic          evt_q, evt_d;

  // Candidate tracking; a zero count means no candidate is held
  always_comb begin
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    acc_d    = acc_q;
    nocode_d = nocode_q;
    evt_d    = 1'b0;
    if (Clear) begin
      nocode_d = 1'b1;
      cnt_d    = '0;
    end else if ((cnt_q == '0) || (CodeIn != cand_q)) begin
      cand_d = CodeIn;
      cnt_d  = CW'(1);
    end else if (cnt_q != CW'(FILT_CYCLES)) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(FILT_CYCLES - 1)) begin
        acc_d    = cand_q;
        nocode_d = 1'b0;
        evt_d    = nocode_q || (cand_q != acc_q);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q    <= '0;
      cand_q   <= CODE_STOP;
      acc_q    <= CODE_STOP;
      nocode_q <= 1'b1;
      evt_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      acc_q    <= acc_d;
      nocode_q <= nocode_d;
      evt_q    <= evt_d;
    end
  end

  assign AccCode = acc_q;
  assign CodeEvt = evt_q;

endmodule

// File: rtl/rx_ctrl_fsm.sv
// Receive-side C-PHY lane control FSM: filters the LP control code and
// sequences Stop -> HS entry -> HS burst -> Stop and the LP-request ->
// Yield -> Turnaround path.
// Ports: Clk, Rst (sync, active-high), Enable lane enable, CtrlCode[1:0]
//        decoder code, HsDone burst-end pulse; CtrlDecoderEn, HsSettle,
//        HsRxEn levels, TaReq / ErrCtrl entry pulses, StateOut[3:0] debug.
module rx_ctrl_fsm
  import rx_ctrl_pkg::*;
#(
  parameter int unsigned FILT_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Enable,
  input  logic [1:0] CtrlCode,
  input  logic       HsDone,
  output logic       CtrlDecoderEn,
  output logic       HsSettle,
  output logic       HsRxEn,
  output logic       TaReq,
  output logic       ErrCtrl,
  output logic [3:0] StateOut
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          dec_en_q, dec_en_d;
  logic          hs_settle_q, hs_settle_d;
  logic          hs_rx_en_q, hs_rx_en_d;
  logic          ta_req_q, ta_req_d;
  logic          err_q, err_d;
  logic [1:0]    acc_code;
  logic          code_evt;
  logic          filt_clear_c;

  assign filt_clear_c = is_decoder_off(state_q);

  rx_ctrl_glitch_filter #(
    .FILT_CYCLES(FILT_CYCLES)
  ) u_filter (
    .Clk    (Clk),
    .Rst    (Rst),
    .Clear  (filt_clear_c),
    .CodeIn (CtrlCode),
    .AccCode(acc_code),
    .CodeEvt(code_evt)
  );

  // Next state, counters and registered outputs
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    tmo_d    = tmo_q;

    case (state_q)
      ST_DISABLED:  if (Enable) state_d = ST_WAIT_STOP;
      ST_WAIT_STOP: if (code_evt && (acc_code == CODE_STOP)) state_d = ST_STOP;
      ST_STOP: if (code_evt) begin
        if (acc_code == CODE_HSRQ)        state_d = ST_HS_RQST;
        else if (acc_code == CODE_LPRQ)   state_d = ST_LP_RQST;
        else if (acc_code == CODE_BRIDGE) state_d = ST_ERR;
      end
      ST_HS_RQST: if (code_evt) begin
        if (acc_code == CODE_BRIDGE)    state_d = ST_HS_PREP;
        else if (acc_code == CODE_STOP) state_d = ST_STOP;
        else if (acc_code == CODE_LPRQ) state_d = ST_ERR;
      end
      ST_HS_PREP: begin
        state_d  = ST_HS_SETTLE;
        settle_d = SW'(SETTLE_CYCLES - 1);
      end
      ST_HS_SETTLE: begin
        if (settle_q == '0) state_d = ST_HS_RX;
        else                settle_d = settle_q - SW'(1);
      end
      ST_HS_RX:   if (HsDone) state_d = ST_HS_EXIT;
      ST_HS_EXIT: if (code_evt) state_d = (acc_code == CODE_STOP) ? ST_STOP : ST_ERR;
      ST_LP_RQST: if (code_evt) begin
        if (acc_code == CODE_BRIDGE)    state_d = ST_LP_YIELD;
        else if (acc_code == CODE_STOP) state_d = ST_STOP;
        else if (acc_code == CODE_HSRQ) state_d = ST_ERR;
      end
      ST_LP_YIELD: if (code_evt) begin
        if (acc_code == CODE_LPRQ)      state_d = ST_TA_RQST;
        else if (acc_code == CODE_STOP) state_d = ST_STOP;
        else if (acc_code == CODE_HSRQ) state_d = ST_ERR;
      end
      ST_TA_RQST: if (code_evt) state_d = (acc_code == CODE_STOP) ? ST_STOP : ST_ERR;
      ST_ERR:     if (code_evt && (acc_code == CODE_STOP)) state_d = ST_STOP;
      default:    state_d = ST_DISABLED;
    endcase

    // Timeout only fires when no code transition was taken this cycle
    if (is_timed_state(state_q) && (state_d == state_q) &&
        (tmo_q == TW'(TIMEOUT_CYCLES - 1))) begin
      state_d = ST_ERR;
    end

    if (!Enable) state_d = ST_DISABLED;

    if ((state_d != state_q) || !is_timed_state(state_q)) tmo_d = '0;
    else                                                  tmo_d = tmo_q + TW'(1);

    // Outputs follow the state being entered so they align with state_q
    dec_en_d    = !is_decoder_off(state_d);
    hs_settle_d = (state_d == ST_HS_SETTLE);
    hs_rx_en_d  = (state_d == ST_HS_RX);
    ta_req_d    = (state_d == ST_TA_RQST) && (state_q != ST_TA_RQST);
    err_d       = (state_d == ST_ERR) && (state_q != ST_ERR);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= ST_DISABLED;
      settle_q    <= '0;
      tmo_q       <= '0;
      dec_en_q    <= 1'b0;
      hs_settle_q <= 1'b0;
      hs_rx_en_q  <= 1'b0;
      ta_req_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      tmo_q       <= tmo_d;
      dec_en_q    <= dec_en_d;
      hs_settle_q <= hs_settle_d;
      hs_rx_en_q  <= hs_rx_en_d;
      ta_req_q    <= ta_req_d;
      err_q       <= err_d;
    end
  end

  assign CtrlDecoderEn = dec_en_q;
  assign HsSettle      = hs_settle_q;
  assign HsRxEn        = hs_rx_en_q;
  assign TaReq         = ta_req_q;
  assign ErrCtrl       = err_q;
  assign StateOut      = state_q;

endmodule

// File: tb/tb_rx_ctrl_fsm.sv
// Directed bench for rx_ctrl_fsm: a per-cycle vector table for the main
// sequences plus hand-written sequences for timeout, disable and reset.
module tb_rx_ctrl_fsm;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Enable;
  logic [1:0] CtrlCode;
  logic       HsDone;
  logic       CtrlDecoderEn;
  logic       HsSettle;
  logic       HsRxEn;
  logic       TaReq;
  logic       ErrCtrl;
  logic [3:0] StateOut;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       en;
    logic [1:0] code;
    logic       done;
    logic [3:0] st;
    logic       settle;
    logic       rx;
    logic       dec;
    logic       ta;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  rx_ctrl_fsm #(
    .FILT_CYCLES   (4),
    .SETTLE_CYCLES (8),
    .TIMEOUT_CYCLES(1024)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Enable       (Enable),
    .CtrlCode     (CtrlCode),
    .HsDone       (HsDone),
    .CtrlDecoderEn(CtrlDecoderEn),
    .HsSettle     (HsSettle),
    .HsRxEn       (HsRxEn),
    .TaReq        (TaReq),
    .ErrCtrl      (ErrCtrl),
    .StateOut     (StateOut)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] outs();
    return 16'({StateOut, HsSettle, HsRxEn, CtrlDecoderEn, TaReq, ErrCtrl});
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic hold(input logic [1:0] code, input int n);
    CtrlCode = code;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_state(input logic [3:0] s, input int max, input string name);
    int k;
    k = 0;
    while (StateOut !== s && k < max) begin
      step();
      k++;
    end
    check(name, 16'(StateOut), 16'(s));
  endtask

  task automatic addn(input int n, input logic [1:0] code, input logic done,
                      input logic [3:0] st, input logic settle, input logic rx,
                      input logic dec, input logic ta, input logic err);
    vec_t v;
    v.en = 1'b1; v.code = code; v.done = done; v.st = st;
    v.settle = settle; v.rx = rx; v.dec = dec; v.ta = ta; v.err = err;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  initial begin
    int cnt;

    //   n  code   done  st     set rx dec ta err
    // HS entry and exit
    addn(1, 2'b00, 1'b0, 4'd1,  0, 0, 1, 0, 0);
    addn(4, 2'b00, 1'b0, 4'd1,  0, 0, 1, 0, 0);
    addn(1, 2'b00, 1'b0, 4'd2,  0, 0, 1, 0, 0);
    addn(4, 2'b01, 1'b0, 4'd2,  0, 0, 1, 0, 0);
    addn(4, 2'b10, 1'b0, 4'd3,  0, 0, 1, 0, 0);
    addn(1, 2'b10, 1'b0, 4'd4,  0, 0, 1, 0, 0);
    addn(8, 2'b10, 1'b0, 4'd5,  1, 0, 0, 0, 0);
    addn(2, 2'b10, 1'b0, 4'd6,  0, 1, 0, 0, 0);
    addn(1, 2'b00, 1'b1, 4'd7,  0, 0, 1, 0, 0);
    addn(4, 2'b00, 1'b0, 4'd7,  0, 0, 1, 0, 0);
    addn(1, 2'b00, 1'b1, 4'd2,  0, 0, 1, 0, 0);
    // Glitch rejection, then HS request aborted back to STOP
    addn(3, 2'b01, 1'b0, 4'd2,  0, 0, 1, 0, 0);
    addn(4, 2'b00, 1'b0, 4'd2,  0, 0, 1, 0, 0);
    addn(4, 2'b01, 1'b0, 4'd2,  0, 0, 1, 0, 0);
    addn(1, 2'b01, 1'b0, 4'd3,  0, 0, 1, 0, 0);
    addn(4, 2'b00, 1'b0, 4'd3,  0, 0, 1, 0, 0);
    addn(1, 2'b00, 1'b1, 4'd2,  0, 0, 1, 0, 0);
    // Turnaround
    addn(4, 2'b11, 1'b0, 4'd2,  0, 0, 1, 0, 0);
    addn(4, 2'b10, 1'b0, 4'd8,  0, 0, 1, 0, 0);
    addn(4, 2'b11, 1'b0, 4'd9,  0, 0, 1, 0, 0);
    addn(1, 2'b00, 1'b0, 4'd10, 0, 0, 1, 1, 0);
    addn(3, 2'b00, 1'b0, 4'd10, 0, 0, 1, 0, 0);
    addn(1, 2'b00, 1'b0, 4'd2,  0, 0, 1, 0, 0);
    // Illegal bridge in STOP
    addn(4, 2'b10, 1'b0, 4'd2,  0, 0, 1, 0, 0);
    addn(1, 2'b00, 1'b0, 4'd11, 0, 0, 1, 0, 1);
    addn(3, 2'b00, 1'b0, 4'd11, 0, 0, 1, 0, 0);
    addn(1, 2'b00, 1'b0, 4'd2,  0, 0, 1, 0, 0);

    // Reset state
    Rst = 1'b1; Enable = 1'b0; CtrlCode = 2'b00; HsDone = 1'b0;
    step(); step();
    check("reset", outs(), 16'h0000);
    Rst = 1'b0;

    foreach (tbl[i]) begin
      Enable = tbl[i].en; CtrlCode = tbl[i].code; HsDone = tbl[i].done;
      step();
      check($sformatf("vec%0d", i), outs(),
            16'({tbl[i].st, tbl[i].settle, tbl[i].rx, tbl[i].dec, tbl[i].ta, tbl[i].err}));
    end
    HsDone = 1'b0;

    // Timeout: constant LP request for TIMEOUT_CYCLES cycles
    hold(2'b11, 4);
    step();
    check("lp_enter", 16'(StateOut), 16'd8);
    cnt = 0;
    while (StateOut == 4'd8 && cnt < 1200) begin
      cnt++;
      step();
    end
    check("tmo_cycles", 16'(cnt), 16'd1024);
    check("tmo_err", outs(), 16'({4'd11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}));
    hold(2'b00, 4);
    check("tmo_err_hold", outs(), 16'({4'd11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}));
    step();
    check("tmo_stop", 16'(StateOut), 16'd2);

    // Disable mid-burst, then re-enable
    hold(2'b01, 4);
    step();
    hold(2'b10, 4);
    wait_state(4'd6, 20, "reach_hs_rx");
    Enable = 1'b0;
    step();
    check("dis_burst", outs(), 16'h0000);
    Enable = 1'b1; CtrlCode = 2'b00;
    step();
    check("reen_wait", 16'(StateOut), 16'd1);
    hold(2'b00, 3);
    check("reen_3smp", 16'(StateOut), 16'd1);
    hold(2'b00, 1);
    check("reen_4smp", 16'(StateOut), 16'd1);
    step();
    check("reen_stop", 16'(StateOut), 16'd2);

    // Disable coinciding with a pending error entry suppresses the pulse
    hold(2'b10, 4);
    Enable = 1'b0;
    step();
    check("dis_pend", outs(), 16'h0000);
    step();
    check("dis_pend2", outs(), 16'h0000);
    Enable = 1'b1; CtrlCode = 2'b00;
    step();
    hold(2'b00, 4);
    step();
    check("dis_pend_stop", 16'(StateOut), 16'd2);

    // Reset during the HS settle window
    hold(2'b01, 4);
    step();
    hold(2'b10, 4);
    step();
    step();
    check("settle_enter", outs(), 16'({4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
    step();
    Rst = 1'b1;
    step();
    check("rst_settle", outs(), 16'h0000);
    Rst = 1'b0;
    step();
    check("rst_recover", 16'(StateOut), 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
